// File: rtl/scalar_mem_bank.sv
// Synchronous memory bank for the scalar processor bus. It has configurable wait states,
// a rdy/err handshake, a write-protected address window and a side preload port.
module scalar_mem_bank #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter int                WAIT_CYC = 1,
  parameter logic [ADDR_W-1:0] RO_BASE  = '0,
  parameter logic [ADDR_W-1:0] RO_LIMIT = ADDR_W'(8'h2F)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wrt,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdy,
  output logic              err,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  if (longint'(DEPTH) > (longint'(1) << ADDR_W) || WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_param
    $error("scalar_mem_bank: DEPTH must be <= 2**ADDR_W and WAIT_CYC within 0..15");
  end

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = DEPTH[ADDR_W:0];
  localparam logic [3:0]        CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam logic              RO_EN    = (RO_LIMIT >= RO_BASE);
  localparam logic [ADDR_W-1:0] RO_SPAN  = RO_LIMIT - RO_BASE;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              acc_err_q, acc_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              idle, req, clash, ld_ok;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_wr, a_err;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  // Modular offset from RO_BASE avoids an always-true compare when RO_BASE is zero.
  function automatic logic in_ro(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - RO_BASE;
    return RO_EN && (off <= RO_SPAN);
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    idle      = (state_q == S_IDLE);
    req       = idle && (rd ^ wrt);
    clash     = idle && rd && wrt;
    a_addr    = idle ? addr  : addr_q;
    a_wdata   = idle ? wdata : wdata_q;
    a_wr      = idle ? wrt   : wr_q;
    a_err     = !in_range(a_addr) || (a_wr && in_ro(a_addr));

    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    acc_err_d = acc_err_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = ld_addr[IDX_W-1:0];
    mem_wdata = ld_data;

    case (state_q)
      S_IDLE: if (req) begin
        addr_d    = addr;
        wdata_d   = wdata;
        wr_d      = wrt;
        acc_err_d = a_err;
        cnt_d     = CNT_INIT;
        state_d   = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
              else               cnt_d   = cnt_q - 4'd1;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The access itself happens on the edge entering RESP. With zero wait states
    // that is the sampling edge, so the live inputs are used instead of the latched ones.
    if (state_d == S_RESP && state_q != S_RESP) begin
      if (a_wr) begin
        if (!a_err) begin
          mem_we    = 1'b1;
          mem_waddr = a_addr[IDX_W-1:0];
          mem_wdata = a_wdata;
        end
      end else begin
        rdata_d = a_err ? '0 : mem_q[a_addr[IDX_W-1:0]];
      end
    end

    ld_ok = ld_en && idle && !rd && !wrt && in_range(ld_addr);
    if (ld_ok) mem_we = 1'b1;

    rdy_d  = (state_q == S_RESP);
    busy_d = !idle;
    err_d  = clash || (ld_en && !ld_ok) || ((state_q == S_RESP) && acc_err_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      acc_err_q <= 1'b0;
      rdata_q   <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      acc_err_q <= acc_err_d;
      rdata_q   <= rdata_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // NOTE: the array has no reset, so contents survive rst. Only the write enable is
  // gated, which also drops a write that would otherwise commit on a reset edge.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rdata = rdata_q;
  assign rdy   = rdy_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_scalar_mem_bank.sv
// Bench for scalar_mem_bank: four instances (wait states 2/0/3/1, one with DEPTH=128)
// checked against an array model of the bus rules, using directed and random traffic.
module tb_scalar_mem_bank;

  localparam int N_DUT = 4;

  logic       clk, rst;
  logic       rd_s [N_DUT], wrt_s [N_DUT], ld_en_s [N_DUT];
  logic       rdy_s [N_DUT], err_s [N_DUT], busy_s [N_DUT];
  logic [7:0] addr_s [N_DUT], wdata_s [N_DUT], ld_addr_s [N_DUT], ld_data_s [N_DUT];
  logic [7:0] rdata_s [N_DUT];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem_m [N_DUT][256];
  logic [7:0] last_rd [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    scalar_mem_bank #(
      .DATA_W(8), .ADDR_W(8),
      .DEPTH((g == 3) ? 128 : 256),
      .WAIT_CYC((g == 1) ? 0 : (g == 2) ? 3 : (g == 3) ? 1 : 2),
      .RO_BASE(8'h00), .RO_LIMIT(8'h2F)
    ) u_dut (
      .clk(clk), .rst(rst),
      .addr(addr_s[g]), .rd(rd_s[g]), .wrt(wrt_s[g]), .wdata(wdata_s[g]),
      .rdata(rdata_s[g]), .rdy(rdy_s[g]), .err(err_s[g]), .busy(busy_s[g]),
      .ld_en(ld_en_s[g]), .ld_addr(ld_addr_s[g]), .ld_data(ld_data_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- reference model ----------------
  function automatic int wc(input int i);
    return (i == 1) ? 0 : (i == 2) ? 3 : (i == 3) ? 1 : 2;
  endfunction

  function automatic int dp(input int i);
    return (i == 3) ? 128 : 256;
  endfunction

  function automatic logic exp_err(input int i, input bit wr, input logic [7:0] a);
    return (int'(a) >= dp(i)) || (wr && a <= 8'h2F);
  endfunction

  // Applies one bus access to the model and returns the rdata expected after it.
  function automatic logic [7:0] m_access(input int i, input bit wr, input logic [7:0] a,
                                          input logic [7:0] d);
    if (wr) begin
      if (!exp_err(i, 1'b1, a)) mem_m[i][a] = d;
      return last_rd[i];
    end
    last_rd[i] = (int'(a) < dp(i)) ? mem_m[i][a] : 8'h00;
    return last_rd[i];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int i, input logic [7:0] a, input logic [7:0] d, output logic e);
    ld_en_s[i] = 1'b1; ld_addr_s[i] = a; ld_data_s[i] = d;
    step();
    ld_en_s[i] = 1'b0;
    e = err_s[i];
    if (int'(a) < dp(i)) mem_m[i][a] = d;
  endtask

  // Issues one access. ld_mode 1 = preload on the sampling edge, 2 = preload one cycle later.
  // lat is the number of edges after the sampling edge until rdy is seen (-1 if never).
  task automatic access(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input int ld_mode, input logic [7:0] ld_a, input logic [7:0] ld_d,
                        output int lat, output logic [7:0] rdat, output logic err_rdy,
                        output logic err_pre, output bit busy_ok);
    lat = -1; rdat = 'x; err_rdy = 1'bx; err_pre = 1'b0; busy_ok = 1'b1;
    rd_s[i] = !wr; wrt_s[i] = wr; addr_s[i] = a; wdata_s[i] = d;
    if (ld_mode == 1) begin ld_en_s[i] = 1'b1; ld_addr_s[i] = ld_a; ld_data_s[i] = ld_d; end
    for (int k = 0; k < 40 && lat < 0; k++) begin
      step();
      rd_s[i] = 1'b0; wrt_s[i] = 1'b0; ld_en_s[i] = 1'b0;
      if (ld_mode == 2 && k == 0) begin
        ld_en_s[i] = 1'b1; ld_addr_s[i] = ld_a; ld_data_s[i] = ld_d;
      end
      if (busy_s[i] !== (k > 0)) busy_ok = 1'b0;
      if (rdy_s[i] === 1'b1) begin lat = k; rdat = rdata_s[i]; err_rdy = err_s[i]; end
      else if (err_s[i] === 1'b1) err_pre = 1'b1;
    end
    step();
    if (rdy_s[i] !== 1'b0 || busy_s[i] !== 1'b0) busy_ok = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    for (int i = 0; i < N_DUT; i++) begin
      n_checks++; if (rdata_s[i] !== 8'h00) begin n_errors++; $display("FAIL reset_rdata[%0d]: got %h exp 00", i, rdata_s[i]); end
      n_checks++; if (rdy_s[i] !== 1'b0) begin n_errors++; $display("FAIL reset_rdy[%0d]: got %b exp 0", i, rdy_s[i]); end
      n_checks++; if (err_s[i] !== 1'b0) begin n_errors++; $display("FAIL reset_err[%0d]: got %b exp 0", i, err_s[i]); end
      n_checks++; if (busy_s[i] !== 1'b0) begin n_errors++; $display("FAIL reset_busy[%0d]: got %b exp 0", i, busy_s[i]); end
      last_rd[i] = 8'h00;
    end
    rst = 1'b1;
  endtask

  task automatic test_preload_all();
    logic [7:0] d;
    for (int a = 0; a < 256; a++) begin
      for (int i = 0; i < N_DUT; i++) begin
        d = 8'($urandom);
        ld_en_s[i] = 1'b1; ld_addr_s[i] = 8'(a); ld_data_s[i] = d;
        if (a < dp(i)) mem_m[i][a] = d;
      end
      step();
      for (int i = 0; i < N_DUT; i++) begin
        ld_en_s[i] = 1'b0;
        n_checks++;
        if (err_s[i] !== (a >= dp(i))) begin
          n_errors++; $display("FAIL preload_err[%0d] addr %h: got %b exp %b", i, a, err_s[i], a >= dp(i));
        end
      end
    end
  endtask

  task automatic test_read_latency();
    int lat; logic [7:0] rdat; logic e, er, ep; bit bok;
    preload(0, 8'h80, 8'h44, e);
    access(0, 1'b0, 8'h80, 8'h00, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
    void'(m_access(0, 1'b0, 8'h80, 8'h00));
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL rd_latency: got %0d exp 3", lat); end
    n_checks++; if (rdat !== 8'h44) begin n_errors++; $display("FAIL rd_data: got %h exp 44", rdat); end
    n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL rd_err: got %b exp 0", er); end
    n_checks++; if (bok !== 1'b1) begin n_errors++; $display("FAIL rd_busy_window: got %b exp 1", bok); end
  endtask

  task automatic test_write_read();
    int lat; logic [7:0] rdat, exp_rd; logic er, ep; bit bok;
    for (int i = 0; i < 2; i++) begin
      exp_rd = m_access(i, 1'b1, 8'h80, 8'h89);
      access(i, 1'b1, 8'h80, 8'h89, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
      n_checks++; if (lat !== wc(i) + 1) begin n_errors++; $display("FAIL wr_latency[%0d]: got %0d exp %0d", i, lat, wc(i) + 1); end
      n_checks++; if (rdat !== exp_rd) begin n_errors++; $display("FAIL wr_rdata_hold[%0d]: got %h exp %h", i, rdat, exp_rd); end
      n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL wr_err[%0d]: got %b exp 0", i, er); end
      void'(m_access(i, 1'b0, 8'h80, 8'h00));
      access(i, 1'b0, 8'h80, 8'h00, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
      n_checks++; if (rdat !== 8'h89) begin n_errors++; $display("FAIL wr_then_rd[%0d]: got %h exp 89", i, rdat); end
      n_checks++; if (bok !== 1'b1) begin n_errors++; $display("FAIL wr_rd_busy[%0d]: got %b exp 1", i, bok); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_rd;
    exp_rd = m_access(1, 1'b0, 8'h60, 8'h00);
    rd_s[1] = 1'b1; addr_s[1] = 8'h60;
    for (int k = 0; k <= 6; k++) begin
      step();
      if (k == 5) rd_s[1] = 1'b0;
      n_checks++;
      if (rdy_s[1] !== (k % 2 == 1 && k < 6)) begin
        n_errors++; $display("FAIL b2b_rdy k=%0d: got %b exp %b", k, rdy_s[1], k % 2 == 1 && k < 6);
      end
      if (k % 2 == 1 && k < 6) begin
        n_checks++; if (rdata_s[1] !== exp_rd) begin n_errors++; $display("FAIL b2b_rdata k=%0d: got %h exp %h", k, rdata_s[1], exp_rd); end
      end
    end
  endtask

  task automatic test_protect();
    int lat; logic [7:0] rdat; logic e, er, ep; bit bok;
    preload(0, 8'h10, 8'h3C, e);
    access(0, 1'b1, 8'h10, 8'hFF, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL ro_wr_latency: got %0d exp 3", lat); end
    n_checks++; if (er !== 1'b1) begin n_errors++; $display("FAIL ro_wr_err: got %b exp 1", er); end
    void'(m_access(0, 1'b0, 8'h10, 8'h00));
    access(0, 1'b0, 8'h10, 8'h00, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
    n_checks++; if (rdat !== 8'h3C) begin n_errors++; $display("FAIL ro_unchanged: got %h exp 3c", rdat); end
    preload(0, 8'h10, 8'h5A, e);
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL ro_preload_err: got %b exp 0", e); end
    void'(m_access(0, 1'b0, 8'h10, 8'h00));
    access(0, 1'b0, 8'h10, 8'h00, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
    n_checks++; if (rdat !== 8'h5A) begin n_errors++; $display("FAIL ro_preload_rd: got %h exp 5a", rdat); end
  endtask

  task automatic test_conflict();
    int lat; logic [7:0] rdat, alias_v, exp_rd; logic er, ep; bit bok;
    rd_s[0] = 1'b1; wrt_s[0] = 1'b1; addr_s[0] = 8'h80;
    step();
    rd_s[0] = 1'b0; wrt_s[0] = 1'b0;
    n_checks++; if (err_s[0] !== 1'b1) begin n_errors++; $display("FAIL clash_err: got %b exp 1", err_s[0]); end
    n_checks++; if (rdy_s[0] !== 1'b0) begin n_errors++; $display("FAIL clash_rdy: got %b exp 0", rdy_s[0]); end
    step();
    n_checks++; if (err_s[0] !== 1'b0) begin n_errors++; $display("FAIL clash_err_len: got %b exp 0", err_s[0]); end
    n_checks++; if (busy_s[0] !== 1'b0) begin n_errors++; $display("FAIL clash_busy: got %b exp 0", busy_s[0]); end
    void'(m_access(3, 1'b0, 8'hF0, 8'h00));
    access(3, 1'b0, 8'hF0, 8'h00, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
    n_checks++; if (rdat !== 8'h00) begin n_errors++; $display("FAIL oor_rd_data: got %h exp 00", rdat); end
    n_checks++; if (er !== 1'b1) begin n_errors++; $display("FAIL oor_rd_err: got %b exp 1", er); end
    alias_v = ~mem_m[3][8'h70];
    void'(m_access(3, 1'b1, 8'hF0, alias_v));
    access(3, 1'b1, 8'hF0, alias_v, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
    n_checks++; if (er !== 1'b1) begin n_errors++; $display("FAIL oor_wr_err: got %b exp 1", er); end
    exp_rd = m_access(3, 1'b0, 8'h70, 8'h00);
    access(3, 1'b0, 8'h70, 8'h00, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
    n_checks++; if (rdat !== exp_rd) begin n_errors++; $display("FAIL oor_wr_alias: got %h exp %h", rdat, exp_rd); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [7:0] rdat; logic e, er, ep; bit bok, rdy_seen;
    preload(2, 8'h81, 8'h55, e);
    void'(m_access(2, 1'b0, 8'h81, 8'h00));
    access(2, 1'b0, 8'h81, 8'h00, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
    wrt_s[2] = 1'b1; addr_s[2] = 8'h81; wdata_s[2] = 8'h77;
    step();
    wrt_s[2] = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < N_DUT; i++) last_rd[i] = 8'h00;
    n_checks++; if (rdata_s[2] !== 8'h00) begin n_errors++; $display("FAIL abort_rdata: got %h exp 00", rdata_s[2]); end
    n_checks++; if (busy_s[2] !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b exp 0", busy_s[2]); end
    rdy_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rdy_s[2] !== 1'b0 || err_s[2] !== 1'b0) rdy_seen = 1'b1;
      step();
    end
    n_checks++; if (rdy_seen !== 1'b0) begin n_errors++; $display("FAIL abort_no_rdy: got %b exp 0", rdy_seen); end
    void'(m_access(2, 1'b0, 8'h81, 8'h00));
    access(2, 1'b0, 8'h81, 8'h00, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
    n_checks++; if (rdat !== 8'h55) begin n_errors++; $display("FAIL abort_old_value: got %h exp 55", rdat); end
  endtask

  task automatic test_preload_drop();
    int lat; logic [7:0] rdat, exp_rd, old_v; logic er, ep; bit bok;
    for (int mode = 1; mode <= 2; mode++) begin
      old_v  = mem_m[0][8'h30 + mode];
      exp_rd = m_access(0, 1'b0, 8'(8'h20 + mode), 8'h00);
      access(0, 1'b0, 8'(8'h20 + mode), 8'h00, mode, 8'(8'h30 + mode), ~old_v, lat, rdat, er, ep, bok);
      n_checks++; if (ep !== 1'b1) begin n_errors++; $display("FAIL ld_drop_err mode %0d: got %b exp 1", mode, ep); end
      n_checks++; if (rdat !== exp_rd) begin n_errors++; $display("FAIL ld_drop_rd mode %0d: got %h exp %h", mode, rdat, exp_rd); end
      n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL ld_drop_lat mode %0d: got %0d exp 3", mode, lat); end
      exp_rd = m_access(0, 1'b0, 8'(8'h30 + mode), 8'h00);
      access(0, 1'b0, 8'(8'h30 + mode), 8'h00, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
      n_checks++; if (rdat !== exp_rd) begin n_errors++; $display("FAIL ld_drop_mem mode %0d: got %h exp %h", mode, rdat, exp_rd); end
    end
  endtask

  task automatic test_random();
    int lat, kind; logic [7:0] a, d, rdat, exp_rd; logic e, er, ep, x_err; bit wr, bok;
    for (int i = 0; i < N_DUT; i++) begin
      for (int n = 0; n < 30; n++) begin
        case ($urandom_range(0, 3))
          0:       a = 8'($urandom_range(0, 47));
          1:       a = 8'($urandom_range(240, 255));
          default: a = 8'($urandom);
        endcase
        d    = 8'($urandom);
        kind = $urandom_range(0, 9);
        if (kind < 2) begin
          preload(i, a, d, e);
          n_checks++; if (e !== (int'(a) >= dp(i))) begin n_errors++; $display("FAIL rnd_ld_err[%0d] addr %h: got %b exp %b", i, a, e, int'(a) >= dp(i)); end
        end else begin
          wr     = (kind >= 6);
          x_err  = exp_err(i, wr, a);
          exp_rd = m_access(i, wr, a, d);
          access(i, wr, a, d, 0, 8'h00, 8'h00, lat, rdat, er, ep, bok);
          n_checks++; if (lat !== wc(i) + 1) begin n_errors++; $display("FAIL rnd_lat[%0d]: got %0d exp %0d", i, lat, wc(i) + 1); end
          n_checks++; if (rdat !== exp_rd) begin n_errors++; $display("FAIL rnd_rdata[%0d] %s %h: got %h exp %h", i, wr ? "wr" : "rd", a, rdat, exp_rd); end
          n_checks++; if (er !== x_err) begin n_errors++; $display("FAIL rnd_err[%0d] %s %h: got %b exp %b", i, wr ? "wr" : "rd", a, er, x_err); end
          n_checks++; if ({ep, bok} !== 2'b01) begin n_errors++; $display("FAIL rnd_handshake[%0d]: got early_err=%b busy_ok=%b exp 0/1", i, ep, bok); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      rd_s[i] = 1'b0; wrt_s[i] = 1'b0; ld_en_s[i] = 1'b0;
      addr_s[i] = 8'h00; wdata_s[i] = 8'h00; ld_addr_s[i] = 8'h00; ld_data_s[i] = 8'h00;
    end
    test_reset();
    test_preload_all();
    test_read_latency();
    test_write_read();
    test_back_to_back();
    test_protect();
    test_conflict();
    test_reset_abort();
    test_preload_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/scalar_mem_bank.md
Name: scalar_mem_bank

Overview:
- Parametrised, clocked memory bank for the scalar processor bus (addr/rd/wrt); next generation of the bench RAM model.
- Replaces the zero-latency combinational RAM with a synchronous bank: configurable depth, data width and wait states, plus a rdy/err handshake.
- Adds a write-protected region and a preload port for program/data images.
- Used as the processor's memory in system benches and as the basis for the synthesizable memory wrapper.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of implemented words; must be ≤ 2^ADDR_W.
- WAIT_CYC, 1, wait states per access; legal range 0..15.
- RO_BASE, 8'h00, first write-protected address, inclusive.
- RO_LIMIT, 8'h2F, last write-protected address, inclusive. RO_LIMIT < RO_BASE disables protection.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- addr  in  ADDR_W  access address.
- rd  in  1  read strobe.
- wrt  in  1  write strobe.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; holds the last completed read.
- rdy  out  1  one-cycle access-complete pulse.
- err  out  1  one-cycle error pulse.
- busy  out  1  high while an access is in flight (WAIT or RESP).
- ld_en  in  1  preload write enable; ignores write protection.
- ld_addr  in  ADDR_W  preload address.
- ld_data  in  DATA_W  preload data.

Behaviour:
- Reset: applied when rst=0 at a clk edge.
  - Outputs: rdata=0, rdy=0, err=0, busy=0.
  - State goes to IDLE and the wait counter clears.
  - Array contents are not modified.
  - Reset during WAIT/RESP aborts the access; a pending write is not committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Request sampled when exactly one of rd/wrt is 1; addr, wdata and op are latched.
  - Next state is WAIT with cnt=WAIT_CYC-1, or RESP directly if WAIT_CYC=0.
  - rd=wrt=1: no access, state stays IDLE, err=1 for the next cycle.
- WAIT: cnt decrements each cycle; go to RESP when cnt=0. busy=1.
- RESP: lasts exactly one cycle; rdy=1, busy=1. Returns to IDLE.
  - rd/wrt are not sampled at the edge leaving RESP.
- Latency: request sampled at edge N → rdy high during cycle after edge N+1+WAIT_CYC.
  - WAIT_CYC=0 gives rdy in the cycle after edge N+1.
  - A held strobe repeats the access every WAIT_CYC+2 cycles; the requester drops the strobe during the rdy cycle.
- Strobe changes while busy are ignored; latched values are used.
- Read: array read on the edge entering RESP; rdata updates at that edge and holds until the next successful read.
- Write: committed at the edge entering RESP; rdata unchanged.
- Address ≥ DEPTH:
  - Read returns rdata=0.
  - Write is dropped.
  - err=1 coincident with rdy.
- Write with RO_BASE ≤ addr ≤ RO_LIMIT: dropped; rdy still pulses, err=1 coincident with rdy.
- Preload:
  - ld_en=1 in IDLE with no rd/wrt at that edge → mem[ld_addr] <= ld_data. No rdy; protection bypassed.
  - ld_en with ld_addr ≥ DEPTH: dropped, err pulse next cycle.
  - ld_en while busy, or coincident with a sampled request: request wins, preload dropped, err pulse next cycle.
- Width rules:
  - Addresses compared unsigned over the full ADDR_W.
  - No partial-word writes.
- Flagged as error at elaboration: DEPTH > 2^ADDR_W, or WAIT_CYC outside 0..15.

Test Plan:
- Preload mem[80h]=44h via ld_en; WAIT_CYC=2; rd at 80h sampled at edge 10 → rdy high after edge 13, rdata=44h, err=0, busy high for cycles after edges 11–13.
- wrt 80h, wdata=89h, then rd 80h → second rdy shows rdata=89h. Repeat with WAIT_CYC=0 → rdy one cycle after each sample, back-to-back every 2 cycles.
- wrt 10h (inside 00h–2Fh) with wdata=FFh → rdy and err pulse together; a later rd 10h returns the preloaded value. ld_en to 10h with 5Ah succeeds, and rd returns 5Ah.
- rd=wrt=1 in IDLE → no rdy, err=1 for one cycle, busy=0. DEPTH=128: rd F0h → rdata=00h with err; wrt F0h → no array change.
- wrt 81h, 77h with WAIT_CYC=3; rst=0 one cycle after the sample → rdy never pulses, outputs zero; rd 81h afterwards returns the old value 55h.
- ld_en asserted while busy, and ld_en coincident with rd → preload dropped, err pulse; the rd completes normally with correct rdata.
